reg_wb_unit: RTL and testbench

- Write-side initiator for the 32x32 register file.
- Collects writeback results from the ALU and load unit through valid/ready handshakes and buffers them in a small in-order queue.
- Drives the register file's single write port (reg_write, rd, write_data) and holds off writes in cycles where the datapath needs the file's read path.
- Provides forwarding lookups so rs1/rs2 reads see queued, not-yet-written values.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/reg_wb_unit.sv | 113 +++++++++++
 tb/tb_reg_wb_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file widths and the writeback entry record used by the
// writeback queue and its forwarding logic.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue. Entries are also presented oldest-first
// (slot 0 = head) so the forwarding logic can pick the youngest match.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head_entry,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output wb_entry_t [DEPTH-1:0]        entries,
    output logic [DEPTH-1:0]             valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_entry;
    end

    assign head_entry = mem[head];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries[k] = mem[head + PW'(k)];
            valid[k]   = (CW'(k) < count);
        end
    end

endmodule

// File: rtl/reg_wb_unit.sv
// Writeback initiator for the register file: arbitrates load/ALU results
// into the queue, drains it through the single write port, and forwards.
module reg_wb_unit #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int AW    = riscv_pkg::REG_AW,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     ld_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    output logic                     alu_ready,
    input  logic                     rd_req,
    output logic                     reg_write,
    output logic [AW-1:0]            rd,
    output logic [XLEN-1:0]          write_data,
    input  logic [AW-1:0]            rs1,
    input  logic [AW-1:0]            rs2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [XLEN-1:0]          fwd1_data,
    output logic [XLEN-1:0]          fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);

    import riscv_pkg::*;

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] data;
    } fwd_t;

    wb_entry_t             push_entry;
    wb_entry_t             head_entry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  ld_fire;
    logic                  alu_fire;
    fwd_t                  fwd1;
    fwd_t                  fwd2;

    // Ready does not look at this cycle's pop: no pass-through when full.
    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;
    assign ld_fire   = ld_valid && ld_ready;
    assign alu_fire  = alu_valid && alu_ready;

    always_comb begin
        if (ld_fire) begin
            push_entry.rd   = ld_rd;
            push_entry.data = ld_data;
        end else begin
            push_entry.rd   = alu_rd;
            push_entry.data = alu_data;
        end
        // Writes to x0 complete the handshake but never occupy the queue.
        push = (ld_fire && ld_rd != REG_ZERO) || (alu_fire && alu_rd != REG_ZERO);
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (reg_write),
        .head_entry (head_entry),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .entries    (entries),
        .valid      (valid)
    );

    assign reg_write  = !rst && !empty && !rd_req;
    assign rd         = empty ? '0 : head_entry.rd;
    assign write_data = empty ? '0 : head_entry.data;

    // Slots are oldest-first, so the last match in the scan is the youngest.
    function automatic fwd_t lookup(input logic [AW-1:0] rs,
                                    input wb_entry_t [DEPTH-1:0] ents,
                                    input logic [DEPTH-1:0] vld);
        fwd_t r;
        // NOTE: defaults first so every path assigns the result and no latch forms.
        r.hit  = 1'b0;
        r.data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[k] && rs != REG_ZERO && ents[k].rd == rs) begin
                r.hit  = 1'b1;
                r.data = ents[k].data;
            end
        end
        return r;
    endfunction

    always_comb begin
        fwd1 = lookup(rs1, entries, valid);
        fwd2 = lookup(rs2, entries, valid);
    end

    assign fwd1_hit  = fwd1.hit;
    assign fwd1_data = fwd1.data;
    assign fwd2_hit  = fwd2.hit;
    assign fwd2_data = fwd2.data;

endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed and random checks of reg_wb_unit against a queue-based model
// of the writeback unit's behaviour.
module tb_reg_wb_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        rd_req;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];

    reg_wb_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .rd_req     (rd_req),
        .reg_write  (reg_write),
        .rd         (rd),
        .write_data (write_data),
        .rs1        (rs1),
        .rs2        (rs2),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Youngest queued value for rs, searching from the tail backwards.
    task automatic model_lookup(input logic [4:0] rs, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (rs != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].rd == rs) begin
                    hit  = 1'b1;
                    data = q[i].data;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int          n;
        logic        h1, h2;
        logic [31:0] d1, d2;
        n = q.size();
        model_lookup(rs1, h1, d1);
        model_lookup(rs2, h2, d2);
        check("count",      32'(count),     32'(n));
        check("ld_ready",   32'(ld_ready),  32'(n < DEPTH));
        check("alu_ready",  32'(alu_ready), 32'(n < DEPTH && !ld_valid));
        check("reg_write",  32'(reg_write), 32'(n > 0 && !rd_req && !rst));
        check("rd",         32'(rd),        (n > 0) ? 32'(q[0].rd) : 32'd0);
        check("write_data", write_data,     (n > 0) ? q[0].data : 32'd0);
        check("fwd1_hit",   32'(fwd1_hit),  32'(h1));
        check("fwd1_data",  fwd1_data,      d1);
        check("fwd2_hit",   32'(fwd2_hit),  32'(h2));
        check("fwd2_data",  fwd2_data,      d2);
    endtask

    // One clock: check outputs mid-cycle, then apply the edge to the model.
    task automatic tick();
        int   n;
        logic l_fire, a_fire;
        #1 check_outputs();
        n      = q.size();
        l_fire = ld_valid && n < DEPTH;
        a_fire = alu_valid && n < DEPTH && !ld_valid;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (n > 0 && !rd_req) q.delete(0);
            if (l_fire && ld_rd != 0)       q.push_back('{rd: ld_rd, data: ld_data});
            else if (a_fire && alu_rd != 0) q.push_back('{rd: alu_rd, data: alu_data});
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit lv, input logic [4:0] lr, input logic [31:0] ldt,
                          input bit av, input logic [4:0] ar, input logic [31:0] adt,
                          input bit rq);
        ld_valid  = lv;
        ld_rd     = lr;
        ld_data   = ldt;
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = adt;
        rd_req    = rq;
    endtask

    task automatic idle(input bit rq);
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, rq);
    endtask

    initial begin
        rst = 1'b1;
        rs1 = '0;
        rs2 = '0;
        idle(0);
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Reset state.
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        tick();

        // Single push then write on the next edge.
        set_in(1, 5'd3, 32'hA5A5_A5A5, 0, 5'd0, 32'd0, 0);
        tick();
        idle(0);
        #1;
        check("t1_reg_write", 32'(reg_write), 32'd1);
        check("t1_rd", 32'(rd), 32'd3);
        check("t1_data", write_data, 32'hA5A5_A5A5);
        tick();
        check("t1_count_after", 32'(count), 32'd0);

        // Load has priority over ALU; ALU taken the cycle after.
        set_in(1, 5'd4, 32'h11, 1, 5'd5, 32'h22, 0);
        #1;
        check("t2_ld_ready", 32'(ld_ready), 32'd1);
        check("t2_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        set_in(0, 5'd0, 32'd0, 1, 5'd5, 32'h22, 0);
        #1;
        check("t2_alu_ready_next", 32'(alu_ready), 32'd1);
        check("t2_first_rd", 32'(rd), 32'd4);
        tick();
        idle(0);
        #1;
        check("t2_second_rd", 32'(rd), 32'd5);
        check("t2_second_data", write_data, 32'h22);
        tick();
        tick();

        // Fill the queue under rd_req, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 5'(i), 32'(i * 16'h1111), 0, 5'd0, 32'd0, 1);
            tick();
        end
        set_in(1, 5'd9, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 1);
        #1;
        check("t3_full_ld_ready", 32'(ld_ready), 32'd0);
        check("t3_full_count", 32'(count), 32'd4);
        check("t3_hold_reg_write", 32'(reg_write), 32'd0);
        tick();
        idle(0);
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("t3_drain_write", 32'(reg_write), 32'd1);
            check("t3_drain_rd", 32'(rd), 32'(i));
            tick();
        end
        check("t3_empty_count", 32'(count), 32'd0);

        // Forwarding returns the youngest of two entries for the same rd.
        set_in(1, 5'd7, 32'h1, 0, 5'd0, 32'd0, 1);
        tick();
        set_in(1, 5'd7, 32'h2, 0, 5'd0, 32'd0, 1);
        tick();
        idle(1);
        rs1 = 5'd7;
        rs2 = 5'd0;
        #1;
        check("t4_fwd1_hit", 32'(fwd1_hit), 32'd1);
        check("t4_fwd1_data", fwd1_data, 32'h2);
        check("t4_fwd2_hit", 32'(fwd2_hit), 32'd0);
        tick();
        idle(0);
        tick();
        tick();
        rs1 = '0;

        // x0 results are accepted but dropped.
        set_in(0, 5'd0, 32'd0, 1, 5'd0, 32'h0000_FFFF, 0);
        #1;
        check("t5_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle(0);
        #1;
        check("t5_count", 32'(count), 32'd0);
        check("t5_reg_write", 32'(reg_write), 32'd0);
        tick();

        // Mid-operation reset discards pending writes.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 5'(10 + i), 32'(32'hC0 + i), 0, 5'd0, 32'd0, 1);
            tick();
        end
        idle(0);
        rst = 1'b1;
        #1;
        check("t6_rst_cycle_write", 32'(reg_write), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_count", 32'(count), 32'd0);
        check("t6_reg_write", 32'(reg_write), 32'd0);
        tick();
        set_in(1, 5'd13, 32'h1234_5678, 0, 5'd0, 32'd0, 0);
        tick();
        idle(0);
        #1;
        check("t6_fresh_write", 32'(reg_write), 32'd1);
        check("t6_fresh_rd", 32'(rd), 32'd13);
        tick();

        // Random traffic with small register numbers so forwarding hits often.
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 99) < 30);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) < 2);
            tick();
        end
        rst = 1'b0;
        idle(0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
